// File: rtl/button_conditioner.sv
// Raw board buttons -> synchronized, debounced level plus 1-cycle press/release pulses,
// with optional per-channel auto-repeat. One independent channel per button.

module button_channel #(
  parameter int DB_CYCLES    = 1_000_000,
  parameter int REPEAT_DELAY = 50_000_000,
  parameter int REPEAT_RATE  = 25_000_000,
  parameter int CNT_W        = 26
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  input  logic repeat_en,
  output logic level,
  output logic press,
  output logic release_out
);
  typedef enum logic [2:0] {
    IDLE, PRESS_WAIT, HELD, REPEAT, RELEASE_WAIT
  } state_t;

  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RR_LAST  = CNT_W'(REPEAT_RATE - 1);

  logic             s1, s2;
  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             press_pulse, press_nxt;
  logic             release_pulse, release_nxt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1            <= 1'b0;
      s2            <= 1'b0;
      state         <= IDLE;
      cnt           <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      s1            <= raw;
      s2            <= s1;
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      press_pulse   <= press_nxt;
      release_pulse <= release_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    press_nxt   = 1'b0;
    release_nxt = 1'b0;
    unique case (state)
      IDLE: begin
        if (s2) begin
          state_nxt = PRESS_WAIT;
          cnt_nxt   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!s2) begin
          state_nxt = IDLE;
        end else if (cnt == DB_LAST) begin
          state_nxt = HELD;
          cnt_nxt   = '0;
          press_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      HELD: begin
        if (!s2) begin
          state_nxt = RELEASE_WAIT;
          cnt_nxt   = '0;
        end else if (cnt == RD_LAST) begin
          // Parked at the last delay count until repeat is enabled.
          if (repeat_en) begin
            state_nxt = REPEAT;
            cnt_nxt   = '0;
            press_nxt = 1'b1;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      REPEAT: begin
        if (!s2) begin
          state_nxt = RELEASE_WAIT;
          cnt_nxt   = '0;
        end else if (!repeat_en) begin
          state_nxt = HELD;
          cnt_nxt   = '0;
        end else if (cnt == RR_LAST) begin
          cnt_nxt   = '0;
          press_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      RELEASE_WAIT: begin
        if (s2) begin
          state_nxt = HELD;
          cnt_nxt   = '0;
        end else if (cnt == DB_LAST) begin
          state_nxt   = IDLE;
          cnt_nxt     = '0;
          release_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    level       = (state == HELD) || (state == REPEAT) || (state == RELEASE_WAIT);
    press       = press_pulse;
    release_out = release_pulse;
  end
endmodule

module button_conditioner #(
  parameter int NUM_BTN      = 5,
  parameter int DB_CYCLES    = 1_000_000,
  parameter int REPEAT_DELAY = 50_000_000,
  parameter int REPEAT_RATE  = 25_000_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn_raw,
  input  logic [NUM_BTN-1:0] repeat_en,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release
);
  localparam int MAX_A = (DB_CYCLES > REPEAT_DELAY) ? DB_CYCLES : REPEAT_DELAY;
  localparam int MAX_P = (MAX_A > REPEAT_RATE) ? MAX_A : REPEAT_RATE;
  localparam int CNT_W = (MAX_P > 1) ? $clog2(MAX_P) : 1;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
    button_channel #(
      .DB_CYCLES   (DB_CYCLES),
      .REPEAT_DELAY(REPEAT_DELAY),
      .REPEAT_RATE (REPEAT_RATE),
      .CNT_W       (CNT_W)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .raw        (btn_raw[g]),
      .repeat_en  (repeat_en[g]),
      .level      (btn_level[g]),
      .press      (btn_press[g]),
      .release_out(btn_release[g])
    );
  end
endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with short debounce/repeat timing
// (DB_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3).

module tb_button_conditioner;
  localparam int N = 5;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [N-1:0] btn_raw = '0;
  logic [N-1:0] repeat_en = '0;
  logic [N-1:0] btn_level, btn_press, btn_release;

  int n_cmp = 0;
  int n_err = 0;

  button_conditioner #(
    .NUM_BTN(N), .DB_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_RATE(3)
  ) dut (
    .clk(clk), .rst(rst), .btn_raw(btn_raw), .repeat_en(repeat_en),
    .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release)
  );

  always #5 clk = ~clk;

  // Advance one edge; observe 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int pulses;
    logic [N-1:0] exp_p;

    // 1: reset with every button held, then release reset while still held
    rst = 1'b0; btn_raw = 5'h1f;
    steps(3);
    chk("rst_level",   btn_level,   0);
    chk("rst_press",   btn_press,   0);
    chk("rst_release", btn_release, 0);
    rst = 1'b1;
    steps(6);
    chk("rst_hold_press_e5", btn_press, 0);
    step();
    chk("rst_hold_press_e6", btn_press, 5'h1f);
    chk("rst_hold_level_e6", btn_level, 5'h1f);
    step();
    chk("rst_hold_press_e7", btn_press, 0);
    chk("rst_hold_level_e7", btn_level, 5'h1f);
    btn_raw = '0;
    steps(6);
    chk("rst_rel_e5", btn_release, 0);
    step();
    chk("rst_rel_e6",       btn_release, 5'h1f);
    chk("rst_rel_level_e6", btn_level,   0);
    step();
    chk("rst_rel_e7", btn_release, 0);
    steps(3);

    // 2: clean press and release on bit 1
    btn_raw = 5'b00010;
    steps(6);
    chk("p1_press_e5", btn_press, 0);
    step();
    chk("p1_press_e6", btn_press, 5'b00010);
    chk("p1_level_e6", btn_level, 5'b00010);
    step();
    chk("p1_press_e7", btn_press, 0);
    steps(3);
    btn_raw = '0;
    steps(6);
    chk("p1_rel_e5",   btn_release, 0);
    chk("p1_level_e5", btn_level,   5'b00010);
    step();
    chk("p1_rel_e6",   btn_release, 5'b00010);
    chk("p1_level_e6r", btn_level,  0);
    step();
    chk("p1_rel_e7", btn_release, 0);
    steps(2);

    // 3a: 3-cycle glitch on bit 2 is rejected
    btn_raw = 5'b00100;
    steps(3);
    btn_raw = '0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("glitch_press", btn_press,   0);
      chk("glitch_level", btn_level,   0);
      chk("glitch_rel",   btn_release, 0);
    end

    // 3b: bounce inside RELEASE_WAIT does not release
    btn_raw = 5'b00100;
    steps(7);
    chk("bnc_press", btn_press, 5'b00100);
    steps(2);
    btn_raw = '0;
    steps(2);
    btn_raw = 5'b00100;
    for (int i = 0; i < 12; i++) begin
      step();
      chk("bnc_rel",   btn_release, 0);
      chk("bnc_level", btn_level,   5'b00100);
      chk("bnc_press2", btn_press,  0);
    end
    btn_raw = '0;
    steps(7);
    chk("bnc_final_rel",   btn_release, 5'b00100);
    chk("bnc_final_level", btn_level,   0);
    steps(2);

    // 4: auto-repeat on bit 3; HELD entered at edge 6, repeats at 16,19,22,...
    repeat_en = 5'b01000;
    btn_raw   = 5'b01000;
    pulses = 0;
    for (int e = 0; e <= 40; e++) begin
      step();
      exp_p = ((e == 6) || (e >= 16 && ((e - 16) % 3) == 0)) ? 5'b01000 : 5'b00000;
      chk($sformatf("rep_e%0d", e), btn_press, exp_p);
      if (btn_press[3]) pulses++;
    end
    chk("rep_count", pulses, 10);
    repeat_en = '0;
    for (int i = 0; i < 15; i++) begin
      step();
      chk("rep_off_press", btn_press, 0);
      chk("rep_off_level", btn_level, 5'b01000);
    end
    btn_raw = '0;
    steps(7);
    chk("rep_rel", btn_release, 5'b01000);
    steps(2);

    // 5: bits 0 and 4 rise together, no repeat
    btn_raw = 5'b10001;
    steps(6);
    chk("sim_press_e5", btn_press, 0);
    step();
    chk("sim_press_e6", btn_press, 5'b10001);
    for (int i = 0; i < 20; i++) begin
      step();
      chk("sim_hold_press", btn_press, 0);
      chk("sim_hold_level", btn_level, 5'b10001);
    end
    btn_raw = '0;
    steps(7);
    chk("sim_rel", btn_release, 5'b10001);
    steps(2);

    // 6: reset during PRESS_WAIT on bit 0, raw released before reset ends
    btn_raw = 5'b00001;
    steps(3);
    rst = 1'b0;
    steps(2);
    chk("mid_rst_level", btn_level, 0);
    chk("mid_rst_press", btn_press, 0);
    btn_raw = '0;
    step();
    rst = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      chk("post_rst_press", btn_press,   0);
      chk("post_rst_level", btn_level,   0);
      chk("post_rst_rel",   btn_release, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
